// File: rtl/fp_scoreboard.sv
// rtl/fp_scoreboard.sv - decode-stage scoreboard for the fixed-latency FP execute path
module fp_scoreboard #(
    parameter int NREGS  = 32,
    parameter int LAT_W  = 3,
    parameter int FP_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             IssueFpD,
    input  logic             ExtStallD,
    input  logic             FlushE,
    output logic             FpStallD,
    output logic [NREGS-1:0] BusyMask,
    output logic             FpWbValid,
    output logic [4:0]       FpWbRd,
    output logic             Idle
);

    // One down-counter per register; entry 0 is held at zero and never tracked.
    logic [LAT_W-1:0] cnt [NREGS];
    logic [31:0]      busyExt;
    logic             issueFire;

    // Busy vector derived from the counters, widened to the 5-bit register index space.
    always_comb begin
        BusyMask = '0;
        for (int r = 1; r < NREGS; r++) begin
            BusyMask[r] = (cnt[r] != '0);
        end
        busyExt = '0;
        busyExt[NREGS-1:0] = BusyMask;
    end

    // Stall request: RAW on either source, WAW only when an FP op wants to issue.
    // Deliberately independent of ExtStallD/FlushE to avoid a loop through the hazard unit.
    always_comb begin
        FpStallD = busyExt[Rs1D] | busyExt[Rs2D] | (IssueFpD & busyExt[RdD]);
    end

    assign issueFire = IssueFpD & ~FpStallD & ~ExtStallD & ~FlushE & (RdD != 5'd0);
    assign Idle      = (BusyMask == '0);

    // Writeback announcement: the single counter sitting at 1 completes this cycle.
    always_comb begin
        FpWbValid = 1'b0;
        FpWbRd    = 5'd0;
        for (int r = 1; r < NREGS; r++) begin
            if (cnt[r] == LAT_W'(1)) begin
                FpWbValid = 1'b1;
                FpWbRd    = 5'(r);
            end
        end
    end

    // Counter update: load on issue, otherwise free-running decrement (the FP pipe never stalls).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREGS; r++) begin
                if (issueFire && (RdD == 5'(r))) begin
                    cnt[r] <= LAT_W'(FP_LAT);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

endmodule
